// File: rtl/battle_engine_if.sv
// battle_engine_if: game-side signal bundle for battle_engine (team data, keys, damage handshake, status).
interface battle_engine_if #(
    parameter int TEAM_SIZE = 3,
    parameter int HP_W      = 8,
    parameter int ID_W      = 3
) ();
    localparam int IDX_W = $clog2(TEAM_SIZE);
    logic                      start;
    logic [7:0]                keycode;
    logic [TEAM_SIZE*ID_W-1:0] player_ids;
    logic [TEAM_SIZE*ID_W-1:0] enemy_ids;
    logic [TEAM_SIZE*HP_W-1:0] player_maxhp;
    logic [TEAM_SIZE*HP_W-1:0] enemy_maxhp;
    logic [7:0]                player_speed;
    logic [7:0]                enemy_speed;
    logic                      dmg_req;
    logic                      dmg_is_player;
    logic                      dmg_valid;
    logic [HP_W-1:0]           dmg_value;
    logic [1:0]                move_index;
    logic [IDX_W-1:0]          my_cur;
    logic [IDX_W-1:0]          opp_cur;
    logic [ID_W-1:0]           cur_player_id;
    logic [ID_W-1:0]           cur_enemy_id;
    logic [HP_W-1:0]           player_hp_cur;
    logic [HP_W-1:0]           enemy_hp_cur;
    logic [7:0]                turn_count;
    logic                      busy;
    logic                      end_battle;
    logic                      result;
    modport master (
        output start, keycode, player_ids, enemy_ids, player_maxhp, enemy_maxhp,
               player_speed, enemy_speed, dmg_valid, dmg_value,
        input  dmg_req, dmg_is_player, move_index, my_cur, opp_cur, cur_player_id,
               cur_enemy_id, player_hp_cur, enemy_hp_cur, turn_count, busy, end_battle, result
    );
    modport slave (
        input  start, keycode, player_ids, enemy_ids, player_maxhp, enemy_maxhp,
               player_speed, enemy_speed, dmg_valid, dmg_value,
        output dmg_req, dmg_is_player, move_index, my_cur, opp_cur, cur_player_id,
               cur_enemy_id, player_hp_cur, enemy_hp_cur, turn_count, busy, end_battle, result
    );
endinterface

// File: rtl/battle_engine.sv
// battle_engine: turn-based battle controller with external damage handshake and auto-switching.
// Optional BATTLE_TIMEOUT_EN: Select_Move idle timeout acts as ENTER after TIMEOUT_CYCLES.
module battle_engine #(
    parameter int          TEAM_SIZE      = 3,
    parameter int          HP_W           = 8,
    parameter int          ID_W           = 3,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd12_500_000
) (
    input logic            Clk,
    input logic            Reset_n,
    battle_engine_if.slave bus
);
    localparam int IDX_W = $clog2(TEAM_SIZE);
    localparam logic [7:0] K_W = 8'h1A, K_A = 8'h04, K_S = 8'h16, K_D = 8'h07, K_ENTER = 8'h28;

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_SEL, S_ORDER, S_ATTACK, S_SHOW, S_FAINT, S_WIN, S_LOSE
    } state_t;

    state_t           r_state, w_next;
    logic [HP_W-1:0]  r_hp_p [TEAM_SIZE];
    logic [HP_W-1:0]  r_hp_e [TEAM_SIZE];
    logic [ID_W-1:0]  r_id_p [TEAM_SIZE];
    logic [ID_W-1:0]  r_id_e [TEAM_SIZE];
    logic [IDX_W-1:0] r_my_cur, r_opp_cur, w_my_nxt, w_opp_nxt;
    logic [1:0]       r_move, w_move_nxt;
    logic [7:0]       r_turn, r_prev_key;
    logic             r_result, r_atk_player, r_pending;
    logic             w_ev, w_enter, w_go, w_p_alive, w_e_alive;
    logic [HP_W-1:0]  w_def_hp, w_def_hp_hit;

    // Held keys generate a single event: compare against last cycle's keycode.
    assign w_ev         = (bus.keycode != 8'h00) && (bus.keycode != r_prev_key);
    assign w_enter      = w_ev && (bus.keycode == K_ENTER);
    assign w_def_hp     = r_atk_player ? r_hp_e[r_opp_cur] : r_hp_p[r_my_cur];
    assign w_def_hp_hit = (bus.dmg_value >= w_def_hp) ? '0 : w_def_hp - bus.dmg_value;
    assign w_move_nxt   = !w_ev                                  ? r_move :
                          (bus.keycode == K_W &&  r_move[1])     ? r_move - 2'd2 :
                          (bus.keycode == K_S && !r_move[1])     ? r_move + 2'd2 :
                          (bus.keycode == K_A &&  r_move[0])     ? r_move - 2'd1 :
                          (bus.keycode == K_D && !r_move[0])     ? r_move + 2'd1 : r_move;

`ifdef BATTLE_TIMEOUT_EN
    logic [23:0] r_tmo;
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            r_tmo <= '0;
        else
            r_tmo <= (r_state != S_SEL || w_ev) ? '0 : r_tmo + 24'd1;
    end
    assign w_go = w_enter || (r_state == S_SEL && r_tmo == TIMEOUT_CYCLES - 24'd1);
`else
    assign w_go = w_enter;
`endif

    // Descending scan so the lowest living slot above the current one wins.
    always_comb begin
        w_my_nxt  = r_my_cur;
        w_opp_nxt = r_opp_cur;
        w_p_alive = 1'b0;
        w_e_alive = 1'b0;
        for (int i = TEAM_SIZE - 1; i >= 0; i--) begin
            if (r_hp_p[i] != '0) begin
                w_p_alive = 1'b1;
                if (IDX_W'(i) > r_my_cur && r_hp_p[r_my_cur] == '0) w_my_nxt = IDX_W'(i);
            end
            if (r_hp_e[i] != '0) begin
                w_e_alive = 1'b1;
                if (IDX_W'(i) > r_opp_cur && r_hp_e[r_opp_cur] == '0) w_opp_nxt = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = bus.start ? S_LOAD : S_IDLE;
            S_LOAD:   w_next = S_SEL;
            S_SEL:    w_next = w_go ? S_ORDER : S_SEL;
            S_ORDER:  w_next = S_ATTACK;
            S_ATTACK: w_next = bus.dmg_valid ? S_SHOW : S_ATTACK;
            S_SHOW:   w_next = !w_enter ? S_SHOW :
                               (w_def_hp == '0 || !r_pending) ? S_FAINT : S_ATTACK;
            S_FAINT:  w_next = !w_e_alive ? S_WIN : !w_p_alive ? S_LOSE : S_SEL;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.dmg_req       = r_state == S_ATTACK;
        bus.dmg_is_player = r_atk_player;
        bus.busy          = r_state != S_IDLE;
        bus.end_battle    = r_state == S_WIN || r_state == S_LOSE;
        bus.move_index    = r_move;
        bus.my_cur        = r_my_cur;
        bus.opp_cur       = r_opp_cur;
        bus.cur_player_id = r_id_p[r_my_cur];
        bus.cur_enemy_id  = r_id_e[r_opp_cur];
        bus.player_hp_cur = r_hp_p[r_my_cur];
        bus.enemy_hp_cur  = r_hp_e[r_opp_cur];
        bus.turn_count    = r_turn;
        bus.result        = r_result;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < TEAM_SIZE; i++) begin
                r_hp_p[i] <= '0;
                r_hp_e[i] <= '0;
                r_id_p[i] <= '0;
                r_id_e[i] <= '0;
            end
            r_my_cur     <= '0;
            r_opp_cur    <= '0;
            r_move       <= '0;
            r_turn       <= '0;
            r_prev_key   <= 8'h00;
            r_result     <= 1'b0;
            r_atk_player <= 1'b0;
            r_pending    <= 1'b0;
        end else begin
            r_prev_key <= bus.keycode;
            case (r_state)
                S_LOAD: begin
                    for (int i = 0; i < TEAM_SIZE; i++) begin
                        r_hp_p[i] <= bus.player_maxhp[i*HP_W +: HP_W];
                        r_hp_e[i] <= bus.enemy_maxhp[i*HP_W +: HP_W];
                        r_id_p[i] <= bus.player_ids[i*ID_W +: ID_W];
                        r_id_e[i] <= bus.enemy_ids[i*ID_W +: ID_W];
                    end
                    r_my_cur  <= '0;
                    r_opp_cur <= '0;
                    r_move    <= '0;
                    r_turn    <= '0;
                    r_result  <= 1'b0;
                end
                S_SEL: r_move <= w_move_nxt;
                S_ORDER: begin
                    r_atk_player <= bus.player_speed > bus.enemy_speed;
                    r_pending    <= 1'b1;
                end
                S_ATTACK: begin
                    if (bus.dmg_valid && r_atk_player) r_hp_e[r_opp_cur] <= w_def_hp_hit;
                    if (bus.dmg_valid && !r_atk_player) r_hp_p[r_my_cur] <= w_def_hp_hit;
                end
                S_SHOW: begin
                    if (w_enter && w_def_hp != '0 && r_pending) begin
                        r_atk_player <= ~r_atk_player;
                        r_pending    <= 1'b0;
                    end
                end
                S_FAINT: begin
                    r_my_cur  <= w_my_nxt;
                    r_opp_cur <= w_opp_nxt;
                    if (!w_e_alive) r_result <= 1'b1;
                    if (w_e_alive && w_p_alive && r_turn != 8'hFF) r_turn <= r_turn + 8'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_battle_engine.sv
// tb_battle_engine: directed scoreboard bench for battle_engine (damage requests and battle end events).
module tb_battle_engine;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    battle_engine_if #(.TEAM_SIZE(3), .HP_W(8), .ID_W(3)) bus ();
    battle_engine #(.TEAM_SIZE(3), .HP_W(8), .ID_W(3)) dut (.Clk(clk), .Reset_n(rst_n), .bus(bus.slave));

    typedef struct packed { logic is_end; logic val; } ev_t;
    ev_t exp_q[$];
    int n_total = 0;
    int n_bad = 0;
    logic prev_req = 1'b0;
    logic prev_end = 1'b0;

    task automatic chk(input string nm, input int act, input int req);
        n_total++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s got=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic sb_pop(input logic is_end, input logic v, input string nm);
        ev_t e;
        n_total++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL %s unexpected event got=%0d required=none", nm, v);
        end else begin
            e = exp_q.pop_front();
            if (e.is_end !== is_end || e.val !== v) begin
                n_bad++;
                $display("FAIL %s got kind=%0d val=%0d required kind=%0d val=%0d", nm, is_end, v, e.is_end, e.val);
            end
        end
    endtask

    always @(negedge clk) begin
        if (bus.dmg_req && !prev_req) sb_pop(1'b0, bus.dmg_is_player, "dmg_attacker");
        if (bus.end_battle) begin
            sb_pop(1'b1, bus.result, "end_result");
            chk("end_pulse_width", int'(prev_end), 0);
        end
        prev_req = bus.dmg_req;
        prev_end = bus.end_battle;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input logic [7:0] k);
        bus.keycode = k;
        tick();
        bus.keycode = 8'h00;
        tick();
    endtask

    task automatic push(input logic is_end, input logic v);
        exp_q.push_back('{is_end: is_end, val: v});
    endtask

    task automatic start_battle();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
    endtask

    task automatic attack(input logic [7:0] dmg);
        int w = 0;
        while (!bus.dmg_req && w < 20) begin
            tick();
            w++;
        end
        chk("dmg_req_seen", int'(bus.dmg_req), 1);
        bus.dmg_valid = 1'b1;
        bus.dmg_value = dmg;
        tick();
        bus.dmg_valid = 1'b0;
        bus.dmg_value = 8'd0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        bus.start = 1'b0;
        bus.keycode = 8'h00;
        bus.dmg_valid = 1'b0;
        bus.dmg_value = 8'd0;
        bus.player_ids = {3'd3, 3'd2, 3'd1};
        bus.enemy_ids = {3'd6, 3'd5, 3'd4};
        bus.player_maxhp = {8'd30, 8'd30, 8'd45};
        bus.enemy_maxhp = {8'd30, 8'd30, 8'd40};
        bus.player_speed = 8'd60;
        bus.enemy_speed = 8'd50;
        #12 rst_n = 1'b1;
        tick();
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_dmg_req", int'(bus.dmg_req), 0);
        chk("rst_turn", int'(bus.turn_count), 0);
        chk("rst_move", int'(bus.move_index), 0);
        chk("rst_result", int'(bus.result), 0);
        chk("rst_player_hp", int'(bus.player_hp_cur), 0);

        // async reset while a damage request is outstanding
        start_battle();
        push(1'b0, 1'b1);
        press(8'h28);
        chk("attack_req_high", int'(bus.dmg_req), 1);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("async_dmg_req", int'(bus.dmg_req), 0);
        chk("async_busy", int'(bus.busy), 0);
        chk("async_hp", int'(bus.player_hp_cur), 0);
        rst_n = 1'b1;
        tick();
        start_battle();
        chk("reload_player_hp", int'(bus.player_hp_cur), 45);
        chk("reload_enemy_hp", int'(bus.enemy_hp_cur), 40);

        // player faster: player hits 12, enemy hits 9
        push(1'b0, 1'b1);
        push(1'b0, 1'b0);
        press(8'h28);
        attack(8'd12);
        chk("enemy_hp_after_12", int'(bus.enemy_hp_cur), 28);
        press(8'h28);
        attack(8'd9);
        chk("player_hp_after_9", int'(bus.player_hp_cur), 36);
        press(8'h28);
        chk("turn_count_1", int'(bus.turn_count), 1);
        chk("busy_in_select", int'(bus.busy), 1);

        // speed tie: enemy first
        bus.player_speed = 8'd50;
        push(1'b0, 1'b0);
        push(1'b0, 1'b1);
        press(8'h28);
        attack(8'd1);
        chk("tie_player_hp", int'(bus.player_hp_cur), 35);
        press(8'h28);
        attack(8'd1);
        chk("tie_enemy_hp", int'(bus.enemy_hp_cur), 27);
        press(8'h28);
        chk("turn_count_2", int'(bus.turn_count), 2);

        // cursor: held D gives one step, no wrap
        bus.keycode = 8'h07;
        tick(10);
        bus.keycode = 8'h00;
        tick();
        chk("hold_D", int'(bus.move_index), 1);
        press(8'h16);
        chk("S_to_3", int'(bus.move_index), 3);
        press(8'h16);
        chk("S_stays_3", int'(bus.move_index), 3);
        press(8'h04);
        chk("A_to_2", int'(bus.move_index), 2);
        press(8'h1A);
        chk("W_to_0", int'(bus.move_index), 0);

        // overkill on enemy slot 0: saturate, skip counterattack, switch to slot 1
        do_reset();
        bus.player_speed = 8'd60;
        bus.enemy_maxhp = {8'd30, 8'd20, 8'd5};
        start_battle();
        push(1'b0, 1'b1);
        press(8'h28);
        attack(8'd200);
        chk("overkill_hp", int'(bus.enemy_hp_cur), 0);
        press(8'h28);
        chk("opp_cur_switch", int'(bus.opp_cur), 1);
        chk("switched_enemy_hp", int'(bus.enemy_hp_cur), 20);
        chk("switched_enemy_id", int'(bus.cur_enemy_id), 5);
        chk("turn_after_faint", int'(bus.turn_count), 1);
        tick(3);
        chk("no_second_req", int'(bus.dmg_req), 0);

        // last enemy faints: win
        do_reset();
        bus.enemy_maxhp = {8'd0, 8'd0, 8'd10};
        start_battle();
        push(1'b0, 1'b1);
        push(1'b1, 1'b1);
        press(8'h28);
        attack(8'd50);
        press(8'h28);
        tick(3);
        chk("win_idle", int'(bus.busy), 0);
        chk("win_result_held", int'(bus.result), 1);

        // last player faints: lose
        bus.player_maxhp = {8'd0, 8'd0, 8'd5};
        bus.enemy_maxhp = {8'd0, 8'd0, 8'd40};
        bus.player_speed = 8'd40;
        start_battle();
        chk("load_clears_result", int'(bus.result), 0);
        push(1'b0, 1'b0);
        push(1'b1, 1'b0);
        press(8'h28);
        attack(8'd10);
        press(8'h28);
        tick(3);
        chk("lose_idle", int'(bus.busy), 0);
        chk("lose_result", int'(bus.result), 0);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/battle_engine.md
Name: battle_engine

Overview:
- Parametrised turn-based battle controller; the next generation of the single-team battle FSM.
- Supports a configurable team size, HP width and move-grid cursor.
- Requests damage from an external calculation block over a req/valid handshake, applies saturating HP loss, auto-switches fainted monsters and reports win/lose.
- Sits between the keyboard keycode path and the battle display and stats modules.

Parameters:
- TEAM_SIZE, 3, monsters per side (2..8); IDX_W = $clog2(TEAM_SIZE) is a localparam.
- HP_W, 8, HP and damage width.
- ID_W, 3, monster id width.
- TIMEOUT_CYCLES, 24'd12_500_000, Select_Move idle timeout; used only with BATTLE_TIMEOUT_EN.

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous active-low reset
- start  in  1  begin battle (sampled in Idle only)
- keycode  in  8  current USB keycode
- player_ids  in  TEAM_SIZE*ID_W  player team ids, slot 0 in LSBs
- enemy_ids  in  TEAM_SIZE*ID_W  enemy team ids
- player_maxhp  in  TEAM_SIZE*HP_W  max HP per player slot
- enemy_maxhp  in  TEAM_SIZE*HP_W  max HP per enemy slot
- player_speed  in  8  speed of current player monster
- enemy_speed  in  8  speed of current enemy monster
- dmg_req  out  1  damage request
- dmg_is_player  out  1  1 = player is attacker
- dmg_valid  in  1  damage result valid
- dmg_value  in  HP_W  damage amount
- move_index  out  2  cursor in 2x2 move grid
- my_cur, opp_cur  out  IDX_W  active slot per side
- cur_player_id, cur_enemy_id  out  ID_W  ids of active slots
- player_hp_cur, enemy_hp_cur  out  HP_W  HP of active slots
- turn_count  out  8  completed turns, saturating at 255
- busy  out  1  state != Idle
- end_battle  out  1  one-cycle pulse
- result  out  1  1 = win; held until next start

Behaviour:
- Reset (async, Reset_n=0): state Idle; all HP regs, indices, move_index, turn_count and result cleared to 0; dmg_req, end_battle, busy low; key-history register cleared to 8'h00.
- Key press event: keycode != 0 and keycode != previous-cycle keycode. Holding a key yields exactly one event. Keys: W=1A, A=04, S=16, D=07, ENTER=28.
- Idle: start=1 -> Load. start in any other state is ignored.
- Load (1 cycle):
  - HP[i] <= maxhp[i] for both sides.
  - my_cur, opp_cur, move_index, turn_count <= 0; result <= 0.
  - Next: Select_Move.
- Select_Move: cursor moves on key events only.
  - W: -2 if index >= 2.
  - S: +2 if index <= 1.
  - A: -1 if index odd.
  - D: +1 if index even.
  - No wrap.
  - ENTER -> Order.
- Order (1 cycle): player attacks first if player_speed > enemy_speed; a tie means the enemy attacks first. Records first/second attacker.
- Attack:
  - dmg_req=1; dmg_is_player=current attacker.
  - dmg_req stays high until dmg_valid=1; dmg_valid is ignored while dmg_req=0.
  - On valid: defender HP <= (dmg_value >= HP) ? 0 : HP - dmg_value (saturating, no underflow).
  - dmg_req drops the next cycle. Next: Show.
- Show: waits for ENTER event.
  - If defender HP == 0 -> Faint_Chk (second attack skipped).
  - Else if second attack pending -> Attack with the other side.
  - Else -> Faint_Chk.
- Faint_Chk (1 cycle):
  - For each side whose active HP == 0, the index advances to the lowest slot above the current one with HP != 0.
  - No living enemy -> Win; else no living player -> Lose. Win has priority if both sides are wiped.
  - Otherwise turn_count++ (saturating) -> Select_Move.
- Win / Lose: end_battle=1 for one cycle; result=1 (Win) or 0 (Lose); -> Idle.
- Outputs are registered, or decoded combinationally from registered state only; zero input-to-output combinational paths.

Optional Feature:
- Macro: BATTLE_TIMEOUT_EN.
- Defined: a 24-bit counter runs in Select_Move, cleared on any key event and on state entry. Reaching TIMEOUT_CYCLES-1 behaves exactly as ENTER on the current move_index.
- Undefined: no counter; Select_Move waits indefinitely.

Test Plan:
- Reset_n low mid-Attack with dmg_req=1 -> dmg_req=0, state Idle, HP=0 immediately (async); release with start -> Load reloads maxhp (e.g. 45).
- Load maxhp 45/40; speeds 60/50; ENTER; dmg 12 then 9 -> enemy HP 28, player HP 36; turn_count=1; dmg_is_player order 1 then 0.
- Speeds 50/50 -> first dmg_req has dmg_is_player=0.
- Enemy HP 5, dmg 200 -> HP 0, no second request, opp_cur 0->1 after Faint_Chk.
- Enemy slots 1,2 HP 0 already, slot 0 faints -> Win, end_battle high exactly 1 cycle, result=1.
- Hold D for 10 cycles from index 0 -> index 1 only; then S -> 3; S again -> 3; A -> 2; W -> 0.
